// File: rtl/tbcc_encoder.sv
// ---------------------------------------------------------------------------
// tbcc_encoder
//   Rate-1/2 tail-biting convolutional encoder, K=7, G1=171 (X), G2=133 (Y).
//   Collects one block of BLOCK_BITS randomized bits into a single buffer,
//   preloads the shift state with the last six bits of that block, then
//   replays the block and emits one (X,Y) pair per bit. Input and output
//   phases never overlap.
//
// Parameters
//   BLOCK_BITS : data bits per FEC block (7..1024)
//   CNT_W      : counter width, 2**CNT_W must exceed BLOCK_BITS
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   in_valid   : randomized data bit present
//   in_bit     : randomized data bit
//   in_ready   : encoder accepts in_bit this cycle (registered)
//   out_valid  : coded pair present (registered)
//   out_x      : G1 output bit
//   out_y      : G2 output bit
//   out_last   : final pair of the block
//   out_ready  : downstream accepts the pair this cycle
// ---------------------------------------------------------------------------
module tbcc_encoder #(
  parameter int BLOCK_BITS = 96,
  parameter int CNT_W      = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output logic out_x,
  output logic out_y,
  output logic out_last,
  input  logic out_ready
);

  // Address width actually needed to index the block buffer; CNT_W is at
  // least this wide, so the low bits of a counter are a valid index.
  localparam int AW = (BLOCK_BITS > 1) ? $clog2(BLOCK_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BITS - 1);

  typedef enum logic [1:0] {
    COLLECT,
    PRIME,
    ENCODE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      wr_cnt;
  logic [CNT_W-1:0]      rd_cnt;
  logic [6:1]            st;
  logic [BLOCK_BITS-1:0] blk_mem;

  logic [6:1]            prime_st;
  logic [6:1]            adv_st;
  logic [CNT_W-1:0]      nxt_cnt;
  logic                  cur_u;
  logic                  nxt_u;
  logic                  take_in;

  // st[1] holds the most recent bit, st[6] the oldest.
  function automatic logic [1:0] code_pair(input logic u, input logic [6:1] s);
    code_pair = {u ^ s[1] ^ s[2] ^ s[3] ^ s[6],
                 u ^ s[2] ^ s[3] ^ s[5] ^ s[6]};
  endfunction

  assign take_in = (state == COLLECT) && in_valid && in_ready;

  // The pair after an accepted one is computed from the already-shifted
  // state and the next buffer bit, so a new pair is ready every cycle.
  // When rd_cnt is the last index nxt_u points past the block; that value
  // is never used because the block ends on that acceptance.
  always_comb begin
    prime_st = '0;
    for (int i = 1; i <= 6; i++) begin
      prime_st[i] = blk_mem[BLOCK_BITS - i];
    end
    cur_u   = blk_mem[rd_cnt[AW-1:0]];
    adv_st  = {st[5:1], cur_u};
    nxt_cnt = rd_cnt + 1'b1;
    nxt_u   = blk_mem[nxt_cnt[AW-1:0]];
  end

  // Block buffer: written only while collecting, no reset needed since
  // every location is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (take_in) begin
      blk_mem[wr_cnt[AW-1:0]] <= in_bit;
    end
  end

  // Control FSM with registered handshake and data outputs. The first
  // ENCODE cycle only loads the output register (out_valid still 0), which
  // gives the two-cycle latency from the last input bit to the first pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= COLLECT;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_x     <= 1'b0;
      out_y     <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (take_in) begin
            if (wr_cnt == LAST) begin
              wr_cnt   <= '0;
              in_ready <= 1'b0;
              state    <= PRIME;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end

        PRIME: begin
          st     <= prime_st;
          rd_cnt <= '0;
          state  <= ENCODE;
        end

        ENCODE: begin
          if (!out_valid) begin
            {out_x, out_y} <= code_pair(cur_u, st);
            out_last       <= (rd_cnt == LAST);
            out_valid      <= 1'b1;
          end else if (out_ready) begin
            st <= adv_st;
            if (out_last) begin
              rd_cnt    <= '0;
              out_valid <= 1'b0;
              out_x     <= 1'b0;
              out_y     <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= COLLECT;
            end else begin
              rd_cnt         <= nxt_cnt;
              {out_x, out_y} <= code_pair(nxt_u, adv_st);
              out_last       <= (nxt_cnt == LAST);
            end
          end
        end

        default: begin
          state     <= COLLECT;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbcc_encoder.sv
// ---------------------------------------------------------------------------
// tb_tbcc_encoder
//   Self-checking bench for tbcc_encoder (N=96). Each block's expected pairs
//   come from a circular-convolution model of the code and are queued when
//   the block is driven; they are popped as the DUT hands pairs over.
// ---------------------------------------------------------------------------
module tb_tbcc_encoder;

  localparam int N = 96;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic out_valid;
  logic out_x;
  logic out_y;
  logic out_last;
  logic out_ready;

  typedef struct packed {
    logic x;
    logic y;
    logic last;
  } pair_t;

  pair_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  tbcc_encoder #(
    .BLOCK_BITS(N),
    .CNT_W(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_bit(in_bit),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_x(out_x),
    .out_y(out_y),
    .out_last(out_last),
    .out_ready(out_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tail-biting code as a circular convolution over the block:
  // pair k uses bits k, k-1, ... taken modulo N.
  task automatic pushModel(input logic [N-1:0] blk);
    pair_t p;
    for (int k = 0; k < N; k++) begin
      p.x = blk[k] ^ blk[(k + N - 1) % N] ^ blk[(k + N - 2) % N]
          ^ blk[(k + N - 3) % N] ^ blk[(k + N - 6) % N];
      p.y = blk[k] ^ blk[(k + N - 2) % N] ^ blk[(k + N - 3) % N]
          ^ blk[(k + N - 5) % N] ^ blk[(k + N - 6) % N];
      p.last = (k == N - 1);
      exp_q.push_back(p);
    end
  endtask

  // Drives one block, then drains and checks its pairs.
  //   bp       : random out_ready instead of constant 1
  //   junk     : hold in_valid=1/in_bit=1 during encode (must be ignored)
  //   gaps     : random in_valid bubbles while collecting
  //   abort_at : if >0, assert reset after that many pairs are accepted
  task automatic applyStimulus(input logic [N-1:0] blk, input bit bp, input bit junk,
                               input bit gaps, input int abort_at, input string name);
    int    idx;
    int    budget;
    int    k;
    int    first_k;
    int    pairs;
    bit    stalled;
    bit    aborted;
    pair_t held;
    pair_t e;
    logic [6:1] tail;

    pushModel(blk);
    idx    = 0;
    budget = 0;
    while (idx < N && budget < 10 * N) begin
      @(negedge clk);
      budget++;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
      end else begin
        in_valid = 1'b1;
        in_bit   = blk[idx];
        if (idx == 0) checkOutput({name, "_in_ready_collect"}, in_ready, 1);
        if (in_ready) idx++;
      end
    end
    if (idx != N) checkOutput({name, "_collect_timeout"}, idx, N);

    k       = 0;
    first_k = -1;
    pairs   = 0;
    stalled = 1'b0;
    aborted = 1'b0;
    held    = '0;
    budget  = 0;
    while (exp_q.size() > 0 && !aborted && budget < 20 * N) begin
      @(negedge clk);
      k++;
      budget++;
      in_valid  = junk;
      in_bit    = junk;
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stalled) begin
        checkOutput({name, "_stall_valid"}, out_valid, 1);
        checkOutput({name, "_stall_hold"}, {out_x, out_y, out_last}, held);
      end
      if (out_valid) begin
        if (first_k < 0) begin
          first_k = k;
          checkOutput({name, "_first_latency"}, k, 3);
        end
        checkOutput({name, "_in_ready_encode"}, in_ready, 0);
        if (out_ready) begin
          e = exp_q.pop_front();
          checkOutput($sformatf("%s_pair%0d", name, pairs), {out_x, out_y, out_last}, e);
          pairs++;
          stalled = 1'b0;
          if (abort_at > 0 && pairs == abort_at) begin
            @(posedge clk);
            #2;
            checkOutput({name, "_valid_before_reset"}, out_valid, 1);
            reset = 1'b0;
            #1;
            checkOutput({name, "_reset_valid_drop"}, out_valid, 0);
            checkOutput({name, "_reset_in_ready"}, in_ready, 1);
            exp_q.delete();
            aborted = 1'b1;
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
            reset = 1'b1;
          end
        end else begin
          stalled = 1'b1;
          held    = {out_x, out_y, out_last};
        end
      end else begin
        stalled = 1'b0;
      end
    end

    if (exp_q.size() != 0) begin
      checkOutput({name, "_drain_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end

    if (!aborted) begin
      for (int i = 1; i <= 6; i++) tail[i] = blk[N - i];
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput({name, "_in_ready_after"}, in_ready, 1);
      checkOutput({name, "_valid_after"}, out_valid, 0);
      checkOutput({name, "_tailbite_state"}, dut.st, tail);
    end
  endtask

  initial begin
    logic [N-1:0] blk;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_xyl", {out_x, out_y, out_last}, 0);
    reset = 1'b1;
    @(negedge clk);

    blk = '0;
    applyStimulus(blk, 1'b0, 1'b0, 1'b0, 0, "zeros");
    blk = '1;
    applyStimulus(blk, 1'b0, 1'b0, 1'b0, 0, "ones");
    blk = '0;
    blk[0] = 1'b1;
    applyStimulus(blk, 1'b0, 1'b0, 1'b0, 0, "imp0");
    applyStimulus(blk, 1'b1, 1'b1, 1'b0, 0, "imp0_bp");
    blk = '0;
    blk[N-1] = 1'b1;
    applyStimulus(blk, 1'b0, 1'b0, 1'b0, 0, "imp95");
    blk = {$urandom, $urandom, $urandom};
    applyStimulus(blk, 1'b1, 1'b0, 1'b1, 0, "rand_bp");
    blk = {$urandom, $urandom, $urandom};
    applyStimulus(blk, 1'b0, 1'b0, 1'b0, 40, "abort");
    blk = '1;
    applyStimulus(blk, 1'b0, 1'b0, 1'b0, 0, "ones_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
